phy_tx_serial: RTL and testbench

Two-lane serial transmitter feeding the PHY receive path. It accepts 32-bit words over a valid/ready handshake and buffers one word. It serializes each word MSB-first onto `par_ser_1` and `par_ser_2`, one bit per `clk_32f`, filling every unused slot with the 0xBC idle/comma byte. After reset it sends a fixed sync preamble of idle bytes so the receiver can assert its active flags before any data is sent.

---
 rtl/phy_tx_serial_if.sv | 9 +
 rtl/phy_tx_serial.sv | 112 +++++++++++
 tb/tb_phy_tx_serial.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/phy_tx_serial_if.sv
// Word handshake between a producer and the two-lane serial transmitter.
interface phy_tx_serial_if;
    logic [31:0] data_input;
    logic        valid_input;
    logic        ready_output;

    modport master (output data_input, output valid_input, input ready_output);
    modport slave  (input data_input, input valid_input, output ready_output);
endinterface

// File: rtl/phy_tx_serial.sv
// Two-lane MSB-first serializer with one-word holding register, idle-byte fill
// and a post-reset sync preamble of idle slots.
module phy_tx_lane #(
    parameter int VEC_W = 16
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             load,
    input  logic [VEC_W-1:0] slot,
    output logic             ser
);
    logic [VEC_W-1:0] sh;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset)    sh <= '0;
        else if (load) sh <= slot;
        else           sh <= {sh[VEC_W-2:0], 1'b0};
    end

    assign ser = sh[VEC_W-1];
endmodule

module phy_tx_serial #(
    parameter int           SYNC_SLOTS = 2,
    parameter logic [7:0]   IDLE_BYTE  = 8'hBC
) (
    input  logic            clk_32f,
    input  logic            reset,
    phy_tx_serial_if.slave  tx,
    output logic            par_ser_1,
    output logic            par_ser_2,
    output logic            active_output
);
    localparam int NUM_LANES = 2;
    localparam int VEC_W     = 16;
    localparam int SW        = $clog2(SYNC_SLOTS + 2);
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_SLOTS);

    typedef enum logic {SYNC, ACTIVE} state_t;

    state_t                             state_q, state_d;
    logic [SW-1:0]                      sync_cnt, sync_d;
    logic [3:0]                         cnt;
    logic [31:0]                        hold;
    logic                               hold_full, hold_full_d;
    logic                               boundary, accept, data_load;
    logic [NUM_LANES-1:0][VEC_W-1:0]    slot;
    logic [NUM_LANES-1:0]               ser;

    assign boundary = (cnt == 4'd15);
    assign accept   = tx.valid_input & tx.ready_output;

    always_comb begin
        state_d   = state_q;
        sync_d    = sync_cnt;
        data_load = 1'b0;
        if (boundary) begin
            case (state_q)
                SYNC: begin
                    // The boundary after the last preamble slot is already an ACTIVE load.
                    if (sync_cnt == SYNC_LAST) begin
                        state_d   = ACTIVE;
                        data_load = hold_full;
                    end else begin
                        sync_d = sync_cnt + SW'(1);
                    end
                end
                ACTIVE:  data_load = hold_full;
                default: state_d = SYNC;
            endcase
        end
    end

    // A data load needs hold_full, which keeps ready low, so it never coincides with an accept.
    assign hold_full_d = accept | (hold_full & ~data_load);

    assign slot[0] = data_load ? hold[31:16] : {IDLE_BYTE, IDLE_BYTE};
    assign slot[1] = data_load ? hold[15:0]  : {IDLE_BYTE, IDLE_BYTE};

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q         <= SYNC;
            sync_cnt        <= '0;
            cnt             <= 4'd15;
            hold            <= '0;
            hold_full       <= 1'b0;
            tx.ready_output <= 1'b0;
            active_output   <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync_cnt        <= sync_d;
            cnt             <= cnt + 4'd1;
            hold_full       <= hold_full_d;
            tx.ready_output <= ~hold_full_d;
            active_output   <= (state_d == ACTIVE);
            if (accept) hold <= tx.data_input;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        phy_tx_lane #(.VEC_W(VEC_W)) u_lane (
            .clk_32f (clk_32f),
            .reset   (reset),
            .load    (boundary),
            .slot    (slot[i]),
            .ser     (ser[i])
        );
    end

    assign par_ser_1 = ser[0];
    assign par_ser_2 = ser[1];
endmodule

// File: tb/tb_phy_tx_serial.sv
// Bench for phy_tx_serial: edge-indexed slot model, scenario table, corner sequences, random traffic.
module tb_phy_tx_serial;
    localparam int          SYNC_SLOTS = 2;
    localparam logic [7:0]  IDLE       = 8'hBC;
    localparam logic [31:0] IDLE_W     = {IDLE, IDLE, IDLE, IDLE};
    localparam int          HIST       = 512;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;
    logic par_ser_1, par_ser_2, active_output;

    phy_tx_serial_if tx();

    phy_tx_serial #(.SYNC_SLOTS(SYNC_SLOTS), .IDLE_BYTE(IDLE)) dut (
        .clk_32f       (clk_32f),
        .reset         (reset),
        .tx            (tx),
        .par_ser_1     (par_ser_1),
        .par_ser_2     (par_ser_2),
        .active_output (active_output)
    );

    always #5 clk_32f = ~clk_32f;

    int vectors = 0;
    int miscompares = 0;

    // Model: edge n belongs to slot n/16; slot k may carry data only when k >= SYNC_SLOTS
    // and a word was accepted on an edge strictly before the slot's first edge.
    int          edge_n;
    logic        m_pend, m_ready, last_acc;
    logic [31:0] m_word, m_slot;
    logic        hist1 [HIST];
    logic        hist2 [HIST];

    typedef struct {
        int          present;
        logic [31:0] data;
        int          slot_start;
        logic [15:0] exp1;
        logic [15:0] exp2;
    } vec_t;

    task automatic chk(input string nm, input int e, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at E%0d: got %h, want %h", nm, e, act, exp);
        end
    endtask

    task automatic model_init();
        edge_n = -1; m_pend = 1'b0; m_ready = 1'b0; last_acc = 1'b0;
        m_word = '0; m_slot = '0;
        for (int i = 0; i < HIST; i++) begin hist1[i] = 1'b0; hist2[i] = 1'b0; end
    endtask

    task automatic do_reset();
        tx.valid_input = 1'b0;
        tx.data_input  = '0;
        reset = 1'b0;
        #1;
        chk("rst_lane1",  edge_n, par_ser_1, 0);
        chk("rst_lane2",  edge_n, par_ser_2, 0);
        chk("rst_ready",  edge_n, tx.ready_output, 0);
        chk("rst_active", edge_n, active_output, 0);
        @(negedge clk_32f);
        reset = 1'b1;
        model_init();
    endtask

    task automatic tick(input logic v, input logic [31:0] d);
        int ph;
        tx.valid_input = v;
        tx.data_input  = d;
        @(posedge clk_32f);
        #1;
        edge_n++;
        ph = edge_n % 16;
        last_acc = v && m_ready;
        if (ph == 0) begin
            if (edge_n >= 16 * SYNC_SLOTS && m_pend) begin
                m_slot = m_word;
                m_pend = 1'b0;
            end else begin
                m_slot = IDLE_W;
            end
        end
        if (last_acc) begin m_pend = 1'b1; m_word = d; end
        m_ready = !m_pend;
        if (edge_n < HIST) begin hist1[edge_n] = par_ser_1; hist2[edge_n] = par_ser_2; end
        chk("lane1",  edge_n, par_ser_1, m_slot[31-ph]);
        chk("lane2",  edge_n, par_ser_2, m_slot[15-ph]);
        chk("ready",  edge_n, tx.ready_output, m_ready);
        chk("active", edge_n, active_output, (edge_n >= 16 * SYNC_SLOTS) ? 1 : 0);
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) tick(1'b0, 32'h0);
    endtask

    function automatic logic [15:0] word_at(input int lane, input int start);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = (lane == 1) ? hist1[start+i] : hist2[start+i];
        return w;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [5];
        tbl[0] = '{40, 32'h12345678, 48, 16'h1234, 16'h5678};
        tbl[1] = '{5,  32'hCAFEBABE, 32, 16'hCAFE, 16'hBABE};
        tbl[2] = '{48, 32'hDEADBEEF, 64, 16'hDEAD, 16'hBEEF};
        tbl[3] = '{33, 32'hBCBCBCBC, 48, 16'hBCBC, 16'hBCBC};
        tbl[4] = '{63, 32'h00FF8001, 64, 16'h00FF, 16'h8001};

        tx.valid_input = 1'b0;
        tx.data_input  = '0;
        model_init();
        #2;

        // Preamble with no traffic
        do_reset();
        run_to(47);
        chk("pre_l1_s0", 0,  word_at(1, 0),  16'hBCBC);
        chk("pre_l2_s0", 0,  word_at(2, 0),  16'hBCBC);
        chk("pre_l1_s1", 16, word_at(1, 16), 16'hBCBC);
        chk("pre_l2_s2", 32, word_at(2, 32), 16'hBCBC);

        // Scenario table: single word presented at a given edge
        for (int t = 0; t < 5; t++) begin
            do_reset();
            run_to(tbl[t].present - 1);
            tick(1'b1, tbl[t].data);
            chk("accepted", edge_n, last_acc, 1);
            run_to(tbl[t].slot_start + 31);
            chk("tbl_lane1", tbl[t].slot_start, word_at(1, tbl[t].slot_start), tbl[t].exp1);
            chk("tbl_lane2", tbl[t].slot_start, word_at(2, tbl[t].slot_start), tbl[t].exp2);
            chk("tbl_idle1", tbl[t].slot_start + 16, word_at(1, tbl[t].slot_start + 16), 16'hBCBC);
            chk("tbl_idle2", tbl[t].slot_start + 16, word_at(2, tbl[t].slot_start + 16), 16'hBCBC);
        end

        // Back-to-back words with valid held
        do_reset();
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 32'hAAAA5555);
            if (last_acc) break;
        end
        chk("b2b_w1_acc", edge_n, last_acc, 1);
        for (int i = 0; i < 60; i++) begin
            tick(1'b1, 32'h0F0FF0F0);
            if (last_acc) break;
        end
        chk("b2b_w2_acc", edge_n, last_acc, 1);
        run_to(79);
        chk("b2b_l1_a", 32, word_at(1, 32), 16'hAAAA);
        chk("b2b_l2_a", 32, word_at(2, 32), 16'h5555);
        chk("b2b_l1_b", 48, word_at(1, 48), 16'h0F0F);
        chk("b2b_l2_b", 48, word_at(2, 48), 16'hF0F0);
        chk("b2b_idle", 64, word_at(1, 64), 16'hBCBC);

        // Reset mid-slot with a word in flight; the word must not reappear
        do_reset();
        run_to(39);
        tick(1'b1, 32'h13579BDF);
        chk("mid_acc", edge_n, last_acc, 1);
        run_to(55);
        do_reset();
        run_to(79);
        for (int s = 0; s < 5; s++) begin
            chk("mid_l1", s * 16, word_at(1, s * 16), 16'hBCBC);
            chk("mid_l2", s * 16, word_at(2, s * 16), 16'hBCBC);
        end

        // Random traffic against the model, with one reset in the middle
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            tick($urandom_range(0, 2) != 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
